// File: rtl/mmio_pkg.sv
// Shared constants and types for the CPU data-side MMIO responder.
// Register offsets are word indices taken from addr[7:2].
package mmio_pkg;

    localparam logic [15:0] MMIO_TAG_DEFAULT = 16'hFFFF;

    localparam logic [5:0] OFF_LED       = 6'h00;
    localparam logic [5:0] OFF_SW        = 6'h01;
    localparam logic [5:0] OFF_TMR_LOAD  = 6'h02;
    localparam logic [5:0] OFF_TMR_COUNT = 6'h03;
    localparam logic [5:0] OFF_TMR_CTRL  = 6'h04;
    localparam logic [5:0] OFF_TMR_STAT  = 6'h05;
    localparam logic [5:0] OFF_CYCLE     = 6'h06;

    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;

    typedef enum logic [1:0] {
        TmrIdle = 2'd0,
        TmrRun  = 2'd1,
        TmrDone = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/mmio_timer.sv
// Countdown timer: owns CTRL, COUNT and the sticky EXPIRED flag.
// A CTRL write pre-empts the running step of the same cycle.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] load_val,
    input  logic        ctrl_we,
    input  logic [2:0]  ctrl_wdata,
    input  logic        stat_clr,
    output logic [31:0] count,
    output logic [2:0]  ctrl,
    output logic        expired
);

    tmr_state_e  state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        expired_q, expired_d;
    logic        expire;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= TmrIdle;
            count_q   <= '0;
            ctrl_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ctrl_q    <= ctrl_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ctrl_d  = ctrl_q;
        expire  = 1'b0;
        if (ctrl_we) begin
            ctrl_d = ctrl_wdata;
            if (ctrl_wdata[CTRL_EN]) begin
                count_d = load_val;
                state_d = TmrRun;
            end else begin
                state_d = TmrIdle;
            end
        end else begin
            case (state_q)
                TmrRun: begin
                    if (count_q != '0) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        expire = 1'b1;
                        if (ctrl_q[CTRL_AUTO_RELOAD]) begin
                            count_d = load_val;
                        end else begin
                            state_d         = TmrDone;
                            ctrl_d[CTRL_EN] = 1'b0;
                        end
                    end
                end
                TmrIdle, TmrDone: ;
                default: state_d = TmrIdle;
            endcase
        end

        // Expiry in the same cycle as a clear keeps the flag set.
        expired_d = expired_q;
        if (stat_clr) expired_d = 1'b0;
        if (expire)   expired_d = 1'b1;
    end

    assign count   = (state_q == TmrDone) ? '0 : count_q;
    assign ctrl    = ctrl_q;
    assign expired = expired_q;

endmodule

// File: rtl/mmio_responder.sv
// Data-side responder: decodes MMIO vs. data RAM, holds LED/SW/CYCLE registers
// and the combinational load mux so the single-cycle CPU completes loads in one cycle.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned RAM_AW   = 7,
    parameter logic [15:0] MMIO_TAG = MMIO_TAG_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              dm_we,
    output logic [RAM_AW-1:0] dm_addr,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              irq
);

    logic        mmio_sel;
    logic [5:0]  offset;
    logic        reg_we;
    logic        wr_led, wr_load, wr_ctrl, wr_stat, wr_cycle;

    logic [15:0] led_q;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic [31:0] load_q;
    logic [31:0] cycle_q;
    logic [31:0] reg_rdata;

    logic [31:0] tmr_count;
    logic [2:0]  tmr_ctrl;
    logic        tmr_expired;

    // Bits outside the decoded fields alias and are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^addr;

    assign mmio_sel = (addr[31:16] == MMIO_TAG);
    assign offset   = addr[7:2];
    assign reg_we   = mem_w & mmio_sel;

    assign wr_led   = reg_we && (offset == OFF_LED);
    assign wr_load  = reg_we && (offset == OFF_TMR_LOAD);
    assign wr_ctrl  = reg_we && (offset == OFF_TMR_CTRL);
    assign wr_stat  = reg_we && (offset == OFF_TMR_STAT);
    assign wr_cycle = reg_we && (offset == OFF_CYCLE);

    assign dm_we   = mem_w & ~mmio_sel;
    assign dm_addr = addr[RAM_AW+1:2];
    assign dm_din  = wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            load_q    <= '0;
            cycle_q   <= '0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            if (wr_led)  led_q  <= wdata[15:0];
            if (wr_load) load_q <= wdata;
            cycle_q <= wr_cycle ? '0 : cycle_q + 32'd1;
        end
    end

    mmio_timer u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load_val   (load_q),
        .ctrl_we    (wr_ctrl),
        .ctrl_wdata (wdata[2:0]),
        .stat_clr   (wr_stat & wdata[0]),
        .count      (tmr_count),
        .ctrl       (tmr_ctrl),
        .expired    (tmr_expired)
    );

    always_comb begin
        reg_rdata = '0;
        case (offset)
            OFF_LED:       reg_rdata = {16'h0000, led_q};
            OFF_SW:        reg_rdata = {16'h0000, sw_sync_q};
            OFF_TMR_LOAD:  reg_rdata = load_q;
            OFF_TMR_COUNT: reg_rdata = tmr_count;
            OFF_TMR_CTRL:  reg_rdata = {29'h0, tmr_ctrl};
            OFF_TMR_STAT:  reg_rdata = {31'h0, tmr_expired};
            OFF_CYCLE:     reg_rdata = cycle_q;
            default:       reg_rdata = '0;
        endcase
    end

    assign rdata   = mmio_sel ? reg_rdata : dm_dout;
    assign led_out = led_q;
    assign irq     = tmr_expired & tmr_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: a driver pushes expected responses from a
// behavioural model; a negedge monitor pops and compares what the DUT presents.
`timescale 1ns/1ps
module tb_mmio_responder;

    localparam logic [31:0] A_LED   = 32'hFFFF_0000;
    localparam logic [31:0] A_SW    = 32'hFFFF_0004;
    localparam logic [31:0] A_LOAD  = 32'hFFFF_0008;
    localparam logic [31:0] A_CNT   = 32'hFFFF_000C;
    localparam logic [31:0] A_CTRL  = 32'hFFFF_0010;
    localparam logic [31:0] A_STAT  = 32'hFFFF_0014;
    localparam logic [31:0] A_CYC   = 32'hFFFF_0018;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_w;
    logic [31:0] addr, wdata, rdata;
    logic        dm_we;
    logic [6:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;
    logic [15:0] sw_in, led_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_responder #(.RAM_AW(7), .MMIO_TAG(16'hFFFF)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .mem_w   (mem_w),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .dm_we   (dm_we),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_dout (dm_dout),
        .sw_in   (sw_in),
        .led_out (led_out),
        .irq     (irq)
    );

    // External data RAM the DUT talks to.
    logic [31:0] tb_ram [128];
    always @(posedge clk) if (dm_we) tb_ram[dm_addr] <= dm_din;
    assign dm_dout = tb_ram[dm_addr];

    // Reference model state.
    logic [31:0] m_ram [128];
    logic [15:0] m_led, m_sw1, m_sw2;
    logic [31:0] m_load, m_count, m_cycle;
    logic        m_en, m_auto, m_irqen, m_exp;

    typedef struct {
        logic [31:0] rdata;
        logic [15:0] led;
        logic        irq;
        logic        dm_we;
        logic [6:0]  dm_addr;
        logic [31:0] dm_din;
    } exp_t;

    exp_t sb_q[$];
    bit   req_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:16] != 16'hFFFF) return m_ram[a[8:2]];
        case (a[7:2])
            6'd0:    return {16'h0, m_led};
            6'd1:    return {16'h0, m_sw2};
            6'd2:    return m_load;
            6'd3:    return m_count;
            6'd4:    return {29'h0, m_irqen, m_auto, m_en};
            6'd5:    return {31'h0, m_exp};
            6'd6:    return m_cycle;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_led = '0; m_sw1 = '0; m_sw2 = '0; m_load = '0; m_count = '0; m_cycle = '0;
        m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0;
    endtask

    // One rising edge: the timer runs only while EN is set, and EN drops on one-shot expiry.
    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit          sel = (a[31:16] == 16'hFFFF);
        bit          wr = w && sel;
        int          off = int'(a[7:2]);
        bit          set_exp = 0;
        logic [31:0] load_old = m_load;
        m_sw2 = m_sw1;
        m_sw1 = sw_in;
        m_cycle = (wr && off == 6) ? 32'h0 : m_cycle + 32'd1;
        if (w && !sel) m_ram[a[8:2]] = d;
        if (wr && off == 0) m_led = d[15:0];
        if (wr && off == 2) m_load = d;
        if (wr && off == 4) begin
            m_en = d[0]; m_auto = d[1]; m_irqen = d[2];
            if (d[0]) m_count = load_old;
        end else if (m_en) begin
            if (m_count != 0) m_count = m_count - 1;
            else begin
                set_exp = 1;
                if (m_auto) m_count = load_old;
                else m_en = 0;
            end
        end
        if (wr && off == 5 && d[0]) m_exp = 0;
        if (set_exp) m_exp = 1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        mem_w = w; addr = a; wdata = d;
        e.rdata   = m_read(a);
        e.led     = m_led;
        e.irq     = m_exp & m_irqen;
        e.dm_we   = w && (a[31:16] != 16'hFFFF);
        e.dm_addr = a[8:2];
        e.dm_din  = d;
        sb_q.push_back(e);
        req_valid = 1'b1;
        @(posedge clk);
        model_step(w, a, d);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (req_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("led_out", {16'h0, led_out}, {16'h0, e.led});
                chk("irq", {31'h0, irq}, {31'h0, e.irq});
                chk("dm_we", {31'h0, dm_we}, {31'h0, e.dm_we});
                chk("dm_addr", {25'h0, dm_addr}, {25'h0, e.dm_addr});
                chk("dm_din", dm_din, e.dm_din);
            end
        end
    end

    initial begin
        logic        w;
        logic [31:0] a, d;
        for (int i = 0; i < 128; i++) begin
            tb_ram[i] = '0;
            m_ram[i]  = '0;
        end
        model_reset();
        rstn = 1'b0; mem_w = 1'b0; addr = A_LED; wdata = '0; sw_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led", {16'h0, led_out}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rstn = 1'b1;

        // RAM store/load and LED store/load.
        drive(1, 32'h0000_0010, 32'h1234_5678);
        drive(0, 32'h0000_0010, 32'h0);
        drive(1, A_LED, 32'h0000_00A5);
        drive(0, A_LED, 32'h0);
        drive(1, 32'hFFFF_AB1C, 32'hDEAD_BEEF);
        drive(0, 32'hFFFF_AB1C, 32'h0);
        drive(0, 32'hFFFF_3300, 32'h0);

        // Switch synchronizer.
        sw_in = 16'h8001;
        repeat (3) drive(0, A_SW, 32'h0);

        // One-shot timer with IRQ, then W1C.
        drive(1, A_LOAD, 32'd3);
        drive(1, A_CTRL, 32'h5);
        repeat (5) drive(0, A_STAT, 32'h0);
        drive(0, A_CNT, 32'h0);
        drive(0, A_CTRL, 32'h0);
        drive(1, A_STAT, 32'h1);
        drive(0, A_STAT, 32'h0);

        // Auto-reload, W1C landing on an expiry edge.
        drive(1, A_LOAD, 32'd2);
        drive(1, A_CTRL, 32'h3);
        drive(0, A_CNT, 32'h0);
        drive(0, A_CNT, 32'h0);
        drive(1, A_STAT, 32'h1);
        repeat (4) drive(0, A_STAT, 32'h0);
        drive(1, A_CTRL, 32'h0);
        drive(1, A_STAT, 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) sw_in = 16'($urandom);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom & 32'h0000_FFFF;
            end else begin
                a = {16'hFFFF, 8'($urandom), 3'b000, 3'($urandom_range(0, 7)), 2'($urandom)};
                if (a[7:2] == 6'd2) d = $urandom_range(0, 6);
                if (a[7:2] == 6'd6 && $urandom_range(0, 3) != 0) w = 1'b0;
            end
            drive(w, a, d);
        end

        // Asynchronous reset in the middle of a count with irq asserted.
        drive(1, A_LED, 32'h0000_FFFF);
        drive(1, A_LOAD, 32'd0);
        drive(1, A_CTRL, 32'h7);
        drive(0, A_STAT, 32'h0);
        drive(1, A_LOAD, 32'd9);
        drive(1, A_CTRL, 32'h7);
        repeat (4) drive(0, A_CNT, 32'h0);
        req_valid = 1'b0;
        mem_w = 1'b0;
        #2 rstn = 1'b0;
        #0.5;
        chk("async_led", {16'h0, led_out}, 32'h0);
        chk("async_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        for (int off = 0; off < 7; off++) begin
            addr = A_LED + 32'(off * 4);
            #0.5;
            chk("async_reg", rdata, 32'h0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        repeat (3) drive(0, A_CNT, 32'h0);
        drive(0, A_CTRL, 32'h0);
        drive(0, A_CYC, 32'h0);
        drive(0, A_LED, 32'h0);

        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
